// File: rtl/serial_bus_arbiter.sv
// Arbitrates PC/MDR/MAR word sources onto the 8-bit host bus, sending each word MSB byte first.
// Latency: grant one edge after req seen in IDLE; one byte per accepted cycle; grant_done on last accept.
// Backpressure: byte held while ard_receive_ready is low; optional timeout aborts. Macro SERIAL_BUS_ARB_RR_EN selects round-robin.
module serial_bus_arbiter #(
    parameter int WORD_BYTES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req,
    input  logic [8*WORD_BYTES-1:0] word_pc,
    input  logic [8*WORD_BYTES-1:0] word_mdr,
    input  logic [8*WORD_BYTES-1:0] word_mar,
    input  logic                    ard_receive_ready,
    output logic [7:0]              out_bus,
    output logic                    bus_pc,
    output logic                    bus_mdr,
    output logic                    bus_mar,
    output logic [2:0]              grant_done,
    output logic                    busy,
    output logic                    error
);

    localparam int W  = 8 * WORD_BYTES;
    localparam int IW = $clog2(WORD_BYTES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    // Index of the final byte, and the stall count one below the timeout limit.
    localparam logic [IW-1:0] ILAST = IW'(WORD_BYTES - 1);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state;
    logic [2:0]    sel;
    logic [W-1:0]  hold;
    logic [IW-1:0] idx;
    logic [TW-1:0] tcnt;
    logic [2:0]    win;
    logic [W-1:0]  win_word;
    logic [W-1:0]  hold_shift;

`ifdef SERIAL_BUS_ARB_RR_EN
    // Index of the requester searched first; 0=PC, 1=MDR, 2=MAR.
    logic [1:0]    rr_ptr;

    function automatic logic [2:0] pick_rr(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] g;
        logic [2:0] s;
        g = '0;
        for (int k = 0; k < 3; k++) begin
            s = {1'b0, p} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            if (g == 3'b000 && r[s[1:0]]) g[s[1:0]] = 1'b1;
        end
        return g;
    endfunction

    // After a completed transfer, the search starts at the requester following the winner.
    function automatic logic [1:0] ptr_after(input logic [2:0] g);
        if (g[0])      return 2'd1;
        else if (g[1]) return 2'd2;
        else           return 2'd0;
    endfunction
`else
    function automatic logic [2:0] pick_fixed(input logic [2:0] r);
        if (r[0])      return 3'b001;
        else if (r[1]) return 3'b010;
        else if (r[2]) return 3'b100;
        else           return 3'b000;
    endfunction
`endif

    // Winner selection and its word, evaluated every cycle but only used in IDLE.
    always_comb begin
`ifdef SERIAL_BUS_ARB_RR_EN
        win = pick_rr(req, rr_ptr);
`else
        win = pick_fixed(req);
`endif
        if (win[0])      win_word = word_pc;
        else if (win[1]) win_word = word_mdr;
        else             win_word = word_mar;
        hold_shift = hold << 8;
    end

    // Arbitration/serialisation FSM; the holding register shifts so its top byte is always the next to send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            hold       <= '0;
            idx        <= '0;
            tcnt       <= '0;
            out_bus    <= '0;
            grant_done <= '0;
            busy       <= 1'b0;
            error      <= 1'b0;
`ifdef SERIAL_BUS_ARB_RR_EN
            rr_ptr     <= 2'd0;
`endif
        end else begin
            grant_done <= '0;
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        state   <= SEND;
                        sel     <= win;
                        hold    <= win_word;
                        out_bus <= win_word[W-1 -: 8];
                        idx     <= '0;
                        tcnt    <= '0;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    if (ard_receive_ready) begin
                        tcnt <= '0;
                        if (idx == ILAST) begin
                            grant_done <= sel;
                            sel        <= '0;
                            out_bus    <= '0;
                            busy       <= 1'b0;
                            idx        <= '0;
                            state      <= IDLE;
`ifdef SERIAL_BUS_ARB_RR_EN
                            rr_ptr     <= ptr_after(sel);
`endif
                        end else begin
                            idx     <= idx + 1'b1;
                            hold    <= hold_shift;
                            out_bus <= hold_shift[W-1 -: 8];
                        end
                    end else if (TIMEOUT_CYCLES > 0) begin
                        if (tcnt == TLAST) begin
                            // Host never took the byte: drop the word, flag it, no completion pulse.
                            error   <= 1'b1;
                            sel     <= '0;
                            out_bus <= '0;
                            busy    <= 1'b0;
                            idx     <= '0;
                            tcnt    <= '0;
                            state   <= IDLE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_pc  = sel[0];
    assign bus_mdr = sel[1];
    assign bus_mar = sel[2];

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: directed scenarios plus randomized traffic against a byte-queue model.
// Instance a uses the default timeout; instance b uses a 4-cycle timeout for the abort scenario.
module tb_serial_bus_arbiter;

    localparam int WB   = 2;
    localparam int TO_A = 255;
    localparam int TO_B = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req, req_b;
    logic [15:0] word_pc, word_mdr, word_mar;
    logic        ready, ready_b;

    logic [7:0]  out_bus, out_bus_b;
    logic        bus_pc, bus_mdr, bus_mar;
    logic        bus_pc_b, bus_mdr_b, bus_mar_b;
    logic [2:0]  grant_done, grant_done_b;
    logic        busy, busy_b, error, error_b;

    serial_bus_arbiter #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(TO_A)) dut (
        .clk(clk), .rst(rst), .req(req),
        .word_pc(word_pc), .word_mdr(word_mdr), .word_mar(word_mar),
        .ard_receive_ready(ready), .out_bus(out_bus),
        .bus_pc(bus_pc), .bus_mdr(bus_mdr), .bus_mar(bus_mar),
        .grant_done(grant_done), .busy(busy), .error(error)
    );

    serial_bus_arbiter #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(TO_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b),
        .word_pc(word_pc), .word_mdr(word_mdr), .word_mar(word_mar),
        .ard_receive_ready(ready_b), .out_bus(out_bus_b),
        .bus_pc(bus_pc_b), .bus_mdr(bus_mdr_b), .bus_mar(bus_mar_b),
        .grant_done(grant_done_b), .busy(busy_b), .error(error_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner index (-1 when idle), queue of bytes still to send, stall run length.
    int         m_owner;
    logic [7:0] m_q[$];
    int         m_stall;
    logic       m_err;
    logic [2:0] m_gd;
    int         m_ptr;

    task automatic model_reset();
        m_owner = -1;
        m_q.delete();
        m_stall = 0;
        m_err   = 1'b0;
        m_gd    = 3'b000;
        m_ptr   = 0;
    endtask

    function automatic int model_pick(input logic [2:0] r);
`ifdef SERIAL_BUS_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (m_ptr + k) % 3;
            if (r[c]) return c;
        end
`else
        for (int c = 0; c < 3; c++) if (r[c]) return c;
`endif
        return -1;
    endfunction

    task automatic model_step();
        logic [15:0] wd;
        int          w;
        m_gd = 3'b000;
        if (m_owner < 0) begin
            if (req != 3'b000) begin
                w  = model_pick(req);
                wd = (w == 0) ? word_pc : (w == 1) ? word_mdr : word_mar;
                m_owner = w;
                m_q.delete();
                for (int b = WB - 1; b >= 0; b--) m_q.push_back(wd[8*b +: 8]);
                m_stall = 0;
            end
        end else if (ready) begin
            void'(m_q.pop_front());
            m_stall = 0;
            if (m_q.size() == 0) begin
                m_gd    = 3'(1 << m_owner);
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
            end
        end else begin
            m_stall++;
            if (TO_A > 0 && m_stall == TO_A) begin
                m_err   = 1'b1;
                m_owner = -1;
                m_q.delete();
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] e_out;
        logic [2:0] e_sel;
        e_out = (m_owner >= 0) ? m_q[0] : 8'h00;
        e_sel = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        chk({tag, ".out_bus"}, 32'(out_bus), 32'(e_out));
        chk({tag, ".bus_sel"}, 32'({bus_mar, bus_mdr, bus_pc}), 32'(e_sel));
        chk({tag, ".grant_done"}, 32'(grant_done), 32'(m_gd));
        chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
        chk({tag, ".error"}, 32'(error), 32'(m_err));
    endtask

    // One clock: model advances on the same edge as the DUTs, outputs compared 1ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".out_bus"}, 32'(out_bus), 32'h0);
        chk({tag, ".bus_sel"}, 32'({bus_mar, bus_mdr, bus_pc}), 32'h0);
        chk({tag, ".grant_done"}, 32'(grant_done), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".error"}, 32'(error), 32'h0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [2:0] seq[3];
    int         nseq;
    logic [2:0] exp_seq[3];

    initial begin
        rst = 1'b1; req = 3'b000; req_b = 3'b000;
        ready = 1'b0; ready_b = 1'b0;
        word_pc = '0; word_mdr = '0; word_mar = '0;
        model_reset();

        // Reset state
        #12;
        check_zero("reset");
        chk("reset.error_b", 32'(error_b), 32'h0);
        #1 rst = 1'b0;

        // Single PC transfer, ready tied high
        req = 3'b001; word_pc = 16'hA55A; ready = 1'b1;
        cycle("single1");
        chk("single.byte0", 32'(out_bus), 32'hA5);
        chk("single.bus_pc0", 32'(bus_pc), 32'h1);
        word_pc = 16'h0000;
        cycle("single2");
        chk("single.byte1", 32'(out_bus), 32'h5A);
        chk("single.bus_pc1", 32'(bus_pc), 32'h1);
        cycle("single3");
        chk("single.done", 32'(grant_done), 32'h1);
        chk("single.idle_bus", 32'(out_bus), 32'h0);
        req = 3'b000;

        // Host stall on MDR word
        req = 3'b010; word_mdr = 16'h1234; ready = 1'b0;
        cycle("stall_grant");
        chk("stall.byte0", 32'(out_bus), 32'h12);
        for (int i = 0; i < 10; i++) begin
            cycle("stall_hold");
            chk("stall.held", 32'(out_bus), 32'h12);
        end
        ready = 1'b1;
        cycle("stall_b1");
        chk("stall.byte1", 32'(out_bus), 32'h34);
        cycle("stall_done");
        chk("stall.done", 32'(grant_done), 32'h2);
        chk("stall.error", 32'(error), 32'h0);
        req = 3'b000;

        // Contention with all requests held
        pulse_reset();
        check_zero("reset2");
        word_pc = 16'h1111; word_mdr = 16'h2222; word_mar = 16'h3333;
        req = 3'b111; ready = 1'b1;
        nseq = 0;
        seq = '{default: 3'b000};
        for (int i = 0; i < 9; i++) begin
            cycle("contend");
            if (grant_done != 3'b000 && nseq < 3) begin
                seq[nseq] = grant_done;
                nseq++;
            end
        end
`ifdef SERIAL_BUS_ARB_RR_EN
        exp_seq = '{3'b001, 3'b010, 3'b100};
`else
        exp_seq = '{3'b001, 3'b001, 3'b001};
`endif
        chk("contend.count", 32'(nseq), 32'd3);
        for (int i = 0; i < 3; i++) chk("contend.order", 32'(seq[i]), 32'(exp_seq[i]));
        req = 3'b000;
        cycle("contend_idle");

        // Reset mid-word
        pulse_reset();
        req = 3'b001; word_pc = 16'hBEEF; ready = 1'b1;
        cycle("midrst1");
        cycle("midrst2");
        chk("midrst.byte1", 32'(out_bus), 32'hEF);
        #2 rst = 1'b1;
        #1;
        check_zero("midrst_async");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle("resend1");
        chk("resend.byte0", 32'(out_bus), 32'hBE);
        cycle("resend2");
        chk("resend.byte1", 32'(out_bus), 32'hEF);
        cycle("resend3");
        chk("resend.done", 32'(grant_done), 32'h1);
        req = 3'b000;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req      = 3'($urandom_range(0, 7));
            word_pc  = 16'($urandom);
            word_mdr = 16'($urandom);
            word_mar = 16'($urandom);
            ready    = ($urandom_range(0, 9) < 7);
            cycle("rand");
        end
        req = 3'b000; ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle("drain");

        // Timeout on the 4-cycle instance
        req_b = 3'b100; ready_b = 1'b0;
        cycle("to_grant");
        chk("to.bus_mar_grant", 32'(bus_mar_b), 32'h1);
        chk("to.busy_grant", 32'(busy_b), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle("to_wait");
            chk("to.bus_mar_wait", 32'(bus_mar_b), 32'h1);
            chk("to.error_wait", 32'(error_b), 32'h0);
        end
        cycle("to_abort");
        chk("to.error_set", 32'(error_b), 32'h1);
        chk("to.bus_mar_clr", 32'(bus_mar_b), 32'h0);
        chk("to.no_done", 32'(grant_done_b), 32'h0);
        chk("to.busy_clr", 32'(busy_b), 32'h0);
        req_b = 3'b000;
        for (int i = 0; i < 5; i++) begin
            cycle("to_sticky");
            chk("to.error_sticky", 32'(error_b), 32'h1);
            chk("to.no_done_later", 32'(grant_done_b), 32'h0);
        end
        req_b = 3'b100; ready_b = 1'b1;
        cycle("to_re1");
        cycle("to_re2");
        cycle("to_re3");
        chk("to.redo_done", 32'(grant_done_b), 32'h4);
        chk("to.error_kept", 32'(error_b), 32'h1);
        req_b = 3'b000;
        pulse_reset();
        chk("to.error_reset", 32'(error_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
